// File: rtl/player_motion.sv
// Per-player motion controller: turns debounced button levels into court
// position, jump arc and a time-limited smash window, stepped once per frame.
module player_motion #(
    parameter int unsigned SIDE         = 0,
    parameter int unsigned INIT_X       = 60,
    parameter int unsigned FLOOR_Y      = 30,
    parameter int unsigned NET_X        = 160,
    parameter int unsigned NET_W        = 6,
    parameter int unsigned PLAYER_W     = 32,
    parameter int unsigned SCREEN_W     = 320,
    parameter int unsigned MOVE_STEP    = 2,
    parameter int unsigned JUMP_V       = 384,
    parameter int unsigned GRAVITY      = 16,
    parameter int unsigned LAND_FRAMES  = 4,
    parameter int unsigned SMASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump,
    input  logic       smash_btn,
    input  logic       round_reset,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       is_smash,
    output logic       airborne
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned X_W   = 11;
    localparam int unsigned FX_W  = 16;
    localparam int unsigned SUM_W = 18;
    localparam int unsigned VEL_W = 12;
    localparam int unsigned CNT_W = 4;

    // Horizontal clamp window depends on which half of the court we own.
    localparam logic signed [X_W-1:0] X_LO =
        (SIDE != 0) ? $signed(X_W'(NET_X + NET_W)) : $signed(X_W'(0));
    localparam logic signed [X_W-1:0] X_HI =
        (SIDE != 0) ? $signed(X_W'(SCREEN_W - PLAYER_W))
                    : $signed(X_W'(NET_X - NET_W - PLAYER_W));
    localparam logic signed [X_W-1:0]   STEP_S    = $signed(X_W'(MOVE_STEP));
    localparam logic [POS_W-1:0]        INIT_X_V  = POS_W'(INIT_X);
    localparam logic [FX_W-1:0]         FLOOR_FX  = FX_W'(FLOOR_Y << 6);
    localparam logic signed [SUM_W-1:0] FLOOR_CMP = $signed(SUM_W'(FLOOR_Y << 6));
    localparam logic signed [VEL_W-1:0] JUMP_V_S  = $signed(VEL_W'(JUMP_V));
    localparam logic signed [VEL_W-1:0] GRAV_S    = $signed(VEL_W'(GRAVITY));
    localparam logic [CNT_W-1:0]        LAND_CNT  = CNT_W'(LAND_FRAMES);
    localparam logic [CNT_W-1:0]        SMASH_CNT = CNT_W'(SMASH_FRAMES);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        LAND   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [POS_W-1:0]          pos_x_d;
    logic [FX_W-1:0]           pos_y_fx_q, pos_y_fx_d;
    logic signed [VEL_W-1:0]   vel_y_q, vel_y_d;
    logic [CNT_W-1:0]          land_cnt_q, land_cnt_d;
    logic [CNT_W-1:0]          smash_cnt_q, smash_cnt_d;
    logic                      is_smash_d;
    logic                      smash_used_q, smash_used_d;
    logic                      airborne_d;
    logic                      jump_pend_q, jump_pend_d;
    logic                      smash_pend_q, smash_pend_d;
    logic                      jump_q, jump_q_d;
    logic                      smash_q, smash_q_d;

    logic                      jump_req;
    logic                      smash_req;
    logic signed [X_W-1:0]     x_sum;
    logic signed [VEL_W-1:0]   vel_dec;
    logic signed [SUM_W-1:0]   y_sum;
    logic                      landing;

    assign pos_y = pos_y_fx_q[FX_W-1:6];

    // State and datapath registers; everything resets to the round-start pose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= GROUND;
            pos_x        <= INIT_X_V;
            pos_y_fx_q   <= FLOOR_FX;
            vel_y_q      <= '0;
            land_cnt_q   <= '0;
            smash_cnt_q  <= '0;
            is_smash     <= 1'b0;
            smash_used_q <= 1'b0;
            airborne     <= 1'b0;
            jump_pend_q  <= 1'b0;
            smash_pend_q <= 1'b0;
            jump_q       <= 1'b0;
            smash_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_x        <= pos_x_d;
            pos_y_fx_q   <= pos_y_fx_d;
            vel_y_q      <= vel_y_d;
            land_cnt_q   <= land_cnt_d;
            smash_cnt_q  <= smash_cnt_d;
            is_smash     <= is_smash_d;
            smash_used_q <= smash_used_d;
            airborne     <= airborne_d;
            jump_pend_q  <= jump_pend_d;
            smash_pend_q <= smash_pend_d;
            jump_q       <= jump_q_d;
            smash_q      <= smash_q_d;
        end
    end

    // Next-state logic: edge capture every clk, motion only on frame_tick,
    // round_reset overriding everything.
    always_comb begin
        state_d      = state_q;
        pos_x_d      = pos_x;
        pos_y_fx_d   = pos_y_fx_q;
        vel_y_d      = vel_y_q;
        land_cnt_d   = land_cnt_q;
        smash_cnt_d  = smash_cnt_q;
        is_smash_d   = is_smash;
        smash_used_d = smash_used_q;
        jump_q_d     = jump;
        smash_q_d    = smash_btn;
        landing      = 1'b0;

        // An edge arriving on the tick clk itself still counts for that tick.
        jump_req     = jump_pend_q | (jump & ~jump_q);
        smash_req    = smash_pend_q | (smash_btn & ~smash_q);
        jump_pend_d  = jump_req;
        smash_pend_d = smash_req;

        // Signed horizontal step so moving left of 0 clamps instead of wrapping.
        x_sum = $signed({1'b0, pos_x});
        if (move_left && !move_right) begin
            x_sum = x_sum - STEP_S;
        end else if (move_right && !move_left) begin
            x_sum = x_sum + STEP_S;
        end

        // Gravity applied first, then the new velocity moves the player.
        vel_dec = vel_y_q - GRAV_S;
        y_sum   = $signed({2'b00, pos_y_fx_q}) + $signed({{(SUM_W-VEL_W){vel_dec[VEL_W-1]}}, vel_dec});

        if (frame_tick) begin
            if (x_sum < X_LO) begin
                pos_x_d = POS_W'(X_LO);
            end else if (x_sum > X_HI) begin
                pos_x_d = POS_W'(X_HI);
            end else begin
                pos_x_d = POS_W'(x_sum);
            end

            case (state_q)
                GROUND: begin
                    if (jump_req) begin
                        vel_y_d      = JUMP_V_S;
                        smash_used_d = 1'b0;
                        state_d      = AIR;
                    end
                end
                AIR: begin
                    if (y_sum <= FLOOR_CMP) begin
                        landing     = 1'b1;
                        pos_y_fx_d  = FLOOR_FX;
                        vel_y_d     = '0;
                        land_cnt_d  = LAND_CNT;
                        state_d     = LAND;
                    end else begin
                        pos_y_fx_d  = FX_W'(y_sum);
                        vel_y_d     = vel_dec;
                    end

                    if (landing) begin
                        is_smash_d  = 1'b0;
                        smash_cnt_d = '0;
                    end else if (is_smash) begin
                        smash_cnt_d = smash_cnt_q - CNT_ONE;
                        if (smash_cnt_q == CNT_ONE) begin
                            is_smash_d = 1'b0;
                        end
                    end else if (smash_req && !smash_used_q) begin
                        is_smash_d   = 1'b1;
                        smash_cnt_d  = SMASH_CNT;
                        smash_used_d = 1'b1;
                    end
                end
                LAND: begin
                    land_cnt_d = land_cnt_q - CNT_ONE;
                    if (land_cnt_q == CNT_ONE) begin
                        state_d = GROUND;
                    end
                end
                default: begin
                    state_d = GROUND;
                end
            endcase

            // Requests live for at most one tick.
            jump_pend_d  = 1'b0;
            smash_pend_d = 1'b0;
        end

        if (round_reset) begin
            state_d      = GROUND;
            pos_x_d      = INIT_X_V;
            pos_y_fx_d   = FLOOR_FX;
            vel_y_d      = '0;
            land_cnt_d   = '0;
            smash_cnt_d  = '0;
            is_smash_d   = 1'b0;
            smash_used_d = 1'b0;
            jump_pend_d  = 1'b0;
            smash_pend_d = 1'b0;
            jump_q_d     = 1'b0;
            smash_q_d    = 1'b0;
        end

        airborne_d = (state_d == AIR);
    end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: P1 and P2 instances share stimulus; a reference
// model queues the expected pose per tick and the outputs are checked a
// cycle later.
module tb_player_motion;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       jump = 1'b0;
    logic       smash_btn = 1'b0;
    logic       round_reset = 1'b0;

    logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y;
    logic       p1_is_smash, p1_airborne, p2_is_smash, p2_airborne;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int x1;
        int x2;
        int y;
        int sm;
        int air;
    } exp_t;

    exp_t sb[$];

    // Reference model state (integer pixels, Q.6 vertical)
    int m_x1, m_x2, m_yfx, m_vel, m_state, m_land, m_scnt, m_sm, m_used;
    int m_jp, m_sp;

    always #5 clk = ~clk;

    player_motion #(.SIDE(0), .INIT_X(60)) u_p1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .jump(jump), .smash_btn(smash_btn), .round_reset(round_reset),
        .pos_x(p1_pos_x), .pos_y(p1_pos_y),
        .is_smash(p1_is_smash), .airborne(p1_airborne)
    );

    player_motion #(.SIDE(1), .INIT_X(230)) u_p2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .jump(jump), .smash_btn(smash_btn), .round_reset(round_reset),
        .pos_x(p2_pos_x), .pos_y(p2_pos_y),
        .is_smash(p2_is_smash), .airborne(p2_airborne)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x1 = 60; m_x2 = 230; m_yfx = 30 * 64; m_vel = 0; m_state = 0;
        m_land = 0; m_scnt = 0; m_sm = 0; m_used = 0; m_jp = 0; m_sp = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit rr);
        int dx;
        if (rr) begin
            model_reset();
            return;
        end
        dx = (l && !r) ? -2 : ((r && !l) ? 2 : 0);
        m_x1 = clamp(m_x1 + dx, 0, 122);
        m_x2 = clamp(m_x2 + dx, 166, 288);
        if (m_state == 0) begin
            if (m_jp != 0) begin
                m_vel = 384; m_state = 1; m_used = 0;
            end
        end else if (m_state == 1) begin
            m_vel = m_vel - 16;
            m_yfx = m_yfx + m_vel;
            if (m_yfx <= 30 * 64) begin
                m_yfx = 30 * 64; m_vel = 0; m_sm = 0; m_land = 4; m_state = 2;
            end else if (m_sm != 0) begin
                m_scnt--;
                if (m_scnt == 0) m_sm = 0;
            end else if (m_sp != 0 && m_used == 0) begin
                m_sm = 1; m_scnt = 8; m_used = 1;
            end
        end else begin
            m_land--;
            if (m_land == 0) m_state = 0;
        end
        m_jp = 0;
        m_sp = 0;
    endtask

    task automatic compare_out();
        exp_t e;
        check_eq("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("p1_pos_x", int'(p1_pos_x), e.x1);
            check_eq("p2_pos_x", int'(p2_pos_x), e.x2);
            check_eq("p1_pos_y", int'(p1_pos_y), e.y);
            check_eq("p2_pos_y", int'(p2_pos_y), e.y);
            check_eq("p1_is_smash", int'(p1_is_smash), e.sm);
            check_eq("p2_is_smash", int'(p2_is_smash), e.sm);
            check_eq("p1_airborne", int'(p1_airborne), e.air);
            check_eq("p2_airborne", int'(p2_airborne), e.air);
        end
    endtask

    // One frame: tick driven for one clk, outputs checked a clk later.
    task automatic tick(input bit l, input bit r, input bit rr);
        exp_t e;
        @(negedge clk);
        move_left = l; move_right = r; round_reset = rr; frame_tick = 1'b1;
        model_tick(l, r, rr);
        e.x1 = m_x1; e.x2 = m_x2; e.y = m_yfx / 64; e.sm = m_sm;
        e.air = (m_state == 1) ? 1 : 0;
        sb.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0; round_reset = 1'b0;
        compare_out();
    endtask

    task automatic press_jump();
        @(negedge clk); jump = 1'b1; m_jp = 1;
        @(negedge clk); jump = 1'b0;
    endtask

    task automatic press_smash();
        @(negedge clk); smash_btn = 1'b1; m_sp = 1;
        @(negedge clk); smash_btn = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int smash_ticks;
        int land_n;

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_p1_x", int'(p1_pos_x), 60);
        check_eq("rst_p2_x", int'(p2_pos_x), 230);
        check_eq("rst_y", int'(p1_pos_y), 30);
        check_eq("rst_smash", int'(p1_is_smash), 0);
        check_eq("rst_air", int'(p1_airborne), 0);
        rst_n = 1'b1;

        repeat (10) tick(0, 0, 0);

        repeat (40) tick(0, 1, 0);
        check_eq("sat_right_p1", int'(p1_pos_x), 122);
        check_eq("sat_right_p2", int'(p2_pos_x), 288);
        repeat (70) tick(1, 0, 0);
        check_eq("sat_left_p1", int'(p1_pos_x), 0);
        check_eq("sat_left_p2", int'(p2_pos_x), 166);
        repeat (3) tick(1, 1, 0);

        // Smash request on the ground is dropped.
        press_smash();
        tick(0, 0, 0);
        check_eq("ground_smash", int'(p1_is_smash), 0);

        // First jump: peak, smash window length, landing update.
        press_jump();
        tick(0, 0, 0);
        check_eq("jump_air", int'(p1_airborne), 1);
        peak = 0; smash_ticks = 0; land_n = 0;
        for (int n = 1; n <= 47; n++) begin
            if (n == 5 || n == 20) press_smash();
            tick(0, 1, 0);
            if (int'(p1_pos_y) > peak) peak = int'(p1_pos_y);
            if (n == 24) check_eq("y_at_24", int'(p1_pos_y), 99);
            if (p1_is_smash) smash_ticks++;
            if (land_n == 0 && !p1_airborne) land_n = n;
        end
        check_eq("peak_y", peak, 99);
        check_eq("smash_len", smash_ticks, 8);
        check_eq("land_update", land_n, 47);
        check_eq("land_y", int'(p1_pos_y), 30);

        // Jump during landing lockout is discarded.
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) press_jump();
            tick(0, 0, 0);
        end
        check_eq("lockout_air", int'(p1_airborne), 0);
        tick(0, 0, 0);
        check_eq("lockout_not_held", int'(p1_airborne), 0);
        press_jump();
        tick(0, 0, 0);
        check_eq("rejump_air", int'(p1_airborne), 1);

        // Smash late in the arc is cut off by landing.
        for (int n = 1; n <= 47; n++) begin
            if (n == 44) press_smash();
            tick(1, 0, 0);
            if (n == 46) check_eq("late_smash_on", int'(p1_is_smash), 1);
        end
        check_eq("late_smash_cut", int'(p1_is_smash), 0);

        // round_reset coincident with a tick mid-jump while smashing.
        repeat (4) tick(0, 0, 0);
        press_jump();
        tick(0, 0, 0);
        for (int n = 1; n <= 9; n++) begin
            if (n == 9) press_smash();
            tick(0, 0, 0);
        end
        check_eq("pre_rr_smash", int'(p1_is_smash), 1);
        tick(0, 1, 1);
        check_eq("rr_p1_x", int'(p1_pos_x), 60);
        check_eq("rr_p2_x", int'(p2_pos_x), 230);
        check_eq("rr_y", int'(p2_pos_y), 30);
        check_eq("rr_air", int'(p2_airborne), 0);
        repeat (5) tick(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
